// File: rtl/demux_dispatch_2ch.sv
// demux_dispatch_2ch
// Sequential stage sitting directly in front of a 1-to-2 demux. It accepts a
// valid/ready word stream and picks a destination channel for each word. The
// word is held in a one-entry buffer and offered on a one-hot out_valid pair.
// Each channel has a saturating count of words delivered on it.
//
// Parameters
//   DATA_W    width of the data word
//   CNT_W     width of each per-channel delivery counter
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_data    incoming word
//   in_valid   incoming word present
//   in_ready   block can take a word this cycle
//   sel_mode   0 = steer by in_sel, 1 = steer by internal round-robin pointer
//   in_sel     explicit channel select (used only when sel_mode = 0)
//   out_data   buffered word, shared by both channels
//   out_valid  one-hot offer of the buffered word to channel 0 / channel 1
//   out_ready  per-channel consumer ready
//   cur_sel    channel of the buffered word, drives the demux select
//   cnt0       words delivered on channel 0 (saturating)
//   cnt1       words delivered on channel 1 (saturating)
module demux_dispatch_2ch #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              sel_mode,
   input  logic              in_sel,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_valid,
   input  logic [1:0]        out_ready,
   output logic              cur_sel,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              full;
   logic [DATA_W-1:0] data_q;
   logic              sel_q;
   logic              rr;
   logic [CNT_W-1:0]  cnt0_q;
   logic [CNT_W-1:0]  cnt1_q;

   logic              delivery;
   logic              accept;
   logic              next_sel;

   // Handshake decode. The consumer that is not selected is ignored, and
   // in_ready never looks at in_valid so there is no valid->ready loop.
   // Freeing the buffer in the same cycle it drains lets one word per cycle
   // flow through without a bubble.
   always_comb begin
      delivery = full & out_ready[sel_q];
      in_ready = ~full | delivery;
      accept   = in_valid & in_ready;
      next_sel = sel_mode ? rr : in_sel;
   end

   // Output view: the buffered word is offered only on its own channel, which
   // matches a demux fed with "word present" and selected by cur_sel.
   always_comb begin
      out_data  = data_q;
      cur_sel   = sel_q;
      out_valid = {full & sel_q, full & ~sel_q};
      cnt0      = cnt0_q;
      cnt1      = cnt1_q;
   end

   // Buffer and channel register. A new word overwrites the buffer whether or
   // not the old word is leaving this cycle; a delivery without a new word
   // just clears the full flag and leaves data/select at their old values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full   <= 1'b0;
         data_q <= '0;
         sel_q  <= 1'b0;
      end else if (accept) begin
         full   <= 1'b1;
         data_q <= in_data;
         sel_q  <= next_sel;
      end else if (delivery) begin
         full   <= 1'b0;
      end
   end

   // Round-robin pointer. It only advances when it was actually used to steer
   // a word, so explicit-mode traffic interleaved with alternate-mode traffic
   // does not disturb the alternation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr <= 1'b0;
      end else if (accept && sel_mode) begin
         rr <= ~rr;
      end
   end

   // Delivery counters. Only the counter of the channel being served can
   // move in a given cycle, and each one sticks at its maximum instead of
   // wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (delivery) begin
         if (sel_q) begin
            if (cnt1_q != CNT_MAX) cnt1_q <= cnt1_q + 1'b1;
         end else begin
            if (cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + 1'b1;
         end
      end
   end

endmodule
